alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execute stage directly downstream of the general register file. It consumes the
//  registered rs/rd operand pair and computes one 16-bit ALU or shift operation.
//  It produces a write-back triple (wr, x, write) for the register file and a SZCV
//  flag register for branch evaluation.
//  Shifts run bit-serially through an FSM, one bit per cycle, and use valid/ready
//  handshakes on both sides.
// PARAMETERS
//  WIDTH      16  datapath width; flags and ops below are specified for 16
//  SHAMT_W    4   width of the shift amount field d
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      operand/op bundle present
//  in_ready   out  1      stage can accept the bundle this cycle
//  op         in   4      operation code (see BEHAVIOUR)
//  rs_value   in   16     source operand
//  rd_value   in   16     destination operand (also the shift operand)
//  rd_idx     in   3      destination register index
//  d          in   4      shift amount
//  out_valid  out  1      write-back bundle present
//  out_ready  in   1      consumer accepts bundle
//  wr         out  3      write-back register index (latched rd_idx)
//  x          out  16     write-back value
//  write      out  1      write-back enable; qualified by out_valid
//  flags      out  4      {S,Z,C,V}; updated when a flag-setting op completes
// BEHAVIOUR
//  - Reset (reset=1 at posedge): state=IDLE, out_valid=0, write=0, wr=0, x=0,
//    flags=0. Reset mid-shift abandons the op with no output and no flag change.
//  - in_ready = (state==IDLE) && (!out_valid || out_ready). A transfer occurs when
//    in_valid && in_ready. The op, operands, rd_idx and d are latched.
//  - out_valid holds with x/wr/write stable until out_ready=1. It drops the cycle
//    after the handshake unless a new result loads the same cycle.
//  - Ops:
//    - 0 ADD   x=rd+rs
//    - 1 SUB   x=rd-rs
//    - 2 AND
//    - 3 OR
//    - 4 XOR
//    - 5 CMP   flags of rd-rs, write=0
//    - 6 MOV   x=rs
//    - 8 SLL   logical left
//    - 9 SLR   rotate left
//    - 10 SRL  logical right
//    - 11 SRA  arithmetic right
//    - 7 and 12-15: NOP. out_valid still asserted for 1 bundle, write=0, flags
//      unchanged.
//  - Latency for non-shift ops: accept at edge N, out_valid=1 after edge N+1.
//    Throughput is one op per cycle when out_ready=1.
//  - Shift FSM: IDLE -> SHIFT (d cycles, 1 bit per cycle, counter decrements)
//    -> IDLE with result loaded. out_valid=1 after edge N+1+d. For d=0: x=rd_value,
//    C=0, latency as non-shift. in_ready=0 throughout SHIFT.
//  - Flags (on result load, for ops 0-6 and 8-11):
//    - S=x[15]; Z=(x==0).
//    - ADD: C=carry out of bit 15; V=(rd[15]==rs[15])&&(x[15]!=rd[15]).
//    - SUB/CMP: C=borrow (rd<rs unsigned); V=(rd[15]!=rs[15])&&(x[15]!=rd[15]).
//    - AND/OR/XOR/MOV/SLR: C=0, V=0.
//    - SLL/SRL/SRA: C=last bit shifted out, V=0.
//  - Arithmetic is modulo 2^16. Only a 17-bit internal sum is used for C.
//  - Flags and x are written in the same cycle that out_valid rises for that op.
// TESTING
//  - ADD rd=0x7FFF rs=0x0001, out_ready=1 -> 1 cycle later x=0x8000, write=1,
//    flags S=1 Z=0 C=0 V=1.
//  - CMP rd=0x0003 rs=0x0005 -> write=0, flags S=1 Z=0 C=1 V=0; register file
//    untouched.
//  - SRA rd=0x8001 d=3 -> in_ready=0 for 3 cycles, out_valid at N+4, x=0xF000,
//    C=0. SLL rd=0x4001 d=2 -> x=0x0004, C=1.
//  - Back-pressure: out_ready=0 with a second bundle offered -> in_ready=0 and
//    x/wr held. Raising out_ready releases both in order, with no loss or duplicate.
//  - Reset asserted 2 cycles into SLR d=8 -> next cycle out_valid=0, flags=0,
//    in_ready=1; the op is never output.
//  - Back-to-back ADD, SUB, AND with out_ready=1 -> 3 results on 3 consecutive
//    cycles; SUB 0x0000-0x0001 gives x=0xFFFF, C=1.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute stage: latches one operand/op bundle, runs ALU ops in one cycle or shifts
// bit-serially, and presents a held write-back bundle plus SZCV flags.
module alu_exec_stage #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   rs_value,
    input  logic [WIDTH-1:0]   rd_value,
    input  logic [2:0]         rd_idx,
    input  logic [SHAMT_W-1:0] d,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         wr,
    output logic [WIDTH-1:0]   x,
    output logic               write,
    output logic [3:0]         flags
);

    // state | meaning
    // IDLE  | no shift in progress; a latched bundle (if any) may load the output
    // SHIFT | shifting the latched operand one bit per cycle, cnt_q bits remain
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t             state_q, state_d;
    logic               pend_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2:0]         idx_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               c_q;
    logic               write_q;

    logic               accept, load, is_shift, cnt_tc;
    logic [WIDTH-1:0]   sh_a;
    logic               sh_c;
    logic [WIDTH:0]     sum, dif;
    logic [WIDTH-1:0]   res;
    logic               fc, fv, wen, fen;

    assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    // a latched bundle loads whenever the stage could also take a new one
    assign load     = pend_q && in_ready;
    assign is_shift = (op[3:2] == 2'b10);
    assign cnt_tc   = (cnt_q == SHAMT_W'(1));
    assign write    = write_q && out_valid;

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_shift && (d != '0)) state_d = SHIFT;
            SHIFT:   if (cnt_tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sh_a = a_q;
        sh_c = c_q;
        case (op_q[1:0])
            2'b00:   {sh_c, sh_a} = {a_q, 1'b0};
            2'b01:   begin sh_a = {a_q[WIDTH-2:0], a_q[WIDTH-1]}; sh_c = 1'b0; end
            2'b10:   {sh_a, sh_c} = {1'b0, a_q};
            default: {sh_a, sh_c} = {a_q[WIDTH-1], a_q};
        endcase
    end

    assign sum = {1'b0, a_q} + {1'b0, b_q};
    assign dif = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        res = '0;
        fc  = 1'b0;
        fv  = 1'b0;
        wen = 1'b1;
        fen = 1'b1;
        case (op_q)
            4'd0: begin
                res = sum[WIDTH-1:0];
                fc  = sum[WIDTH];
                fv  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd1, 4'd5: begin
                res = dif[WIDTH-1:0];
                fc  = dif[WIDTH];
                fv  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
                wen = (op_q == 4'd1);
            end
            4'd2:              res = a_q & b_q;
            4'd3:              res = a_q | b_q;
            4'd4:              res = a_q ^ b_q;
            4'd6:              res = b_q;
            4'd8, 4'd10, 4'd11: begin
                res = a_q;
                fc  = c_q;
            end
            4'd9:              res = a_q;
            default: begin
                wen = 1'b0;
                fen = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q    <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            c_q       <= 1'b0;
            out_valid <= 1'b0;
            write_q   <= 1'b0;
            wr        <= '0;
            x         <= '0;
            flags     <= '0;
        end else begin
            if (accept) begin
                pend_q <= 1'b1;
                op_q   <= op;
                a_q    <= rd_value;
                b_q    <= rs_value;
                idx_q  <= rd_idx;
                cnt_q  <= d;
                c_q    <= 1'b0;
            end else if (load) begin
                pend_q <= 1'b0;
            end else if (state_q == SHIFT) begin
                a_q   <= sh_a;
                c_q   <= sh_c;
                cnt_q <= cnt_q - SHAMT_W'(1);
            end

            if (load) begin
                out_valid <= 1'b1;
                x         <= res;
                wr        <= idx_q;
                write_q   <= wen;
                if (fen) flags <= {res[WIDTH-1], res == '0, fc, fv};
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: expected bundles are queued at input
// handshake and compared at output handshake.
module tb_alu_exec_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  op = '0;
    logic [15:0] rs_value = '0;
    logic [15:0] rd_value = '0;
    logic [2:0]  rd_idx = '0;
    logic [3:0]  d = '0;
    logic        in_ready, out_valid, write;
    logic [2:0]  wr;
    logic [15:0] x;
    logic [3:0]  flags;

    alu_exec_stage #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs_value(rs_value), .rd_value(rd_value), .rd_idx(rd_idx), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .wr(wr), .x(x),
        .write(write), .flags(flags)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  wr;
        logic [15:0] x;
        logic        write;
        logic [3:0]  flags;
        logic        chk_lat;
        logic [31:0] acc_cyc;
        logic [31:0] lat;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    logic [3:0] m_flags = '0;
    bit         lat_mode = 0;
    bit         rnd_bp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [15:0] rd,
                                   input logic [15:0] rs, input logic [2:0] idx,
                                   input logic [3:0] dd, input logic [3:0] fl_in);
        exp_t   r;
        int     s, u;
        logic [15:0] v16;
        logic   c, v, we, fe;
        c = 0; v = 0; we = 1; fe = 1; v16 = '0;
        case (o)
            4'd0: begin
                u = int'(rd) + int'(rs);
                s = int'($signed(rd)) + int'($signed(rs));
                v16 = u[15:0]; c = (u > 65535); v = (s > 32767) || (s < -32768);
            end
            4'd1, 4'd5: begin
                s = int'($signed(rd)) - int'($signed(rs));
                v16 = rd - rs; c = (rd < rs); v = (s > 32767) || (s < -32768);
                we = (o == 4'd1);
            end
            4'd2: v16 = rd & rs;
            4'd3: v16 = rd | rs;
            4'd4: v16 = rd ^ rs;
            4'd6: v16 = rs;
            4'd8: begin v16 = rd << dd; c = (dd != 0) ? rd[16 - dd] : 1'b0; end
            4'd9: v16 = (rd << dd) | (rd >> (16 - dd));
            4'd10: begin v16 = rd >> dd; c = (dd != 0) ? rd[dd - 1] : 1'b0; end
            4'd11: begin v16 = $signed(rd) >>> dd; c = (dd != 0) ? rd[dd - 1] : 1'b0; end
            default: begin we = 0; fe = 0; end
        endcase
        r = '0;
        r.wr = idx;
        r.x = v16;
        r.write = we;
        r.flags = fe ? {v16[15], v16 == 16'h0, c, v} : fl_in;
        return r;
    endfunction

    always @(posedge clock) cyc++;

    always @(posedge clock) if (rnd_bp) begin
        #1 out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            m_flags = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("wr", 32'(wr), 32'(e.wr));
                    chk("write", 32'(write), 32'(e.write));
                    if (e.write) chk("x", 32'(x), 32'(e.x));
                    chk("flags", 32'(flags), 32'(e.flags));
                    if (e.chk_lat) chk("latency", cyc - e.acc_cyc, e.lat);
                end
            end
            if (in_valid && in_ready) begin
                e = model(op, rd_value, rs_value, rd_idx, d, m_flags);
                e.chk_lat = lat_mode;
                e.acc_cyc = cyc;
                e.lat = (op[3:2] == 2'b10) ? 32'(d) + 2 : 2;
                m_flags = e.flags;
                sb.push_back(e);
            end
        end
    end

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [3:0] o, input logic [15:0] rd, input logic [15:0] rs,
                        input logic [2:0] idx, input logic [3:0] dd);
        bit ok;
        ok = 0;
        in_valid = 1; op = o; rd_value = rd; rs_value = rs; rd_idx = idx; d = dd;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clock); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && !out_valid) begin ok = 1; break; end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        int n;
        bit ok;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_write", 32'(write), 0);
        chk("rst_wr", 32'(wr), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clock); #1 reset = 0;

        lat_mode = 1;
        send(4'd0, 16'h7FFF, 16'h0001, 3'd3, 4'd0);
        drain();
        chk("add_flags", 32'(flags), 32'b1001);

        send(4'd5, 16'h0003, 16'h0005, 3'd2, 4'd0);
        drain();
        chk("cmp_flags", 32'(flags), 32'b1010);

        send(4'd11, 16'h8001, 16'h0000, 3'd1, 4'd3);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (in_ready) break;
            n++;
        end
        chk("sra_busy_cycles", n, 3);
        @(posedge clock); #1;
        drain();
        chk("sra_flags", 32'(flags), 32'b1000);

        send(4'd8, 16'h4001, 16'h0000, 3'd4, 4'd2);
        drain();
        chk("sll_flags", 32'(flags), 32'b0010);

        send(4'd0, 16'h1234, 16'h1111, 3'd1, 4'd0);
        send(4'd1, 16'h0000, 16'h0001, 3'd2, 4'd0);
        send(4'd2, 16'hF0F0, 16'h3C3C, 3'd3, 4'd0);
        drain();
        lat_mode = 0;

        out_ready = 0;
        send(4'd6, 16'h0000, 16'h1234, 3'd5, 4'd0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (out_valid) begin ok = 1; break; end
        end
        chk("bp_first_valid", 32'(ok), 1);
        @(posedge clock); #1;
        in_valid = 1; op = 4'd4; rd_value = 16'hAAAA; rs_value = 16'h0F0F; rd_idx = 3'd6; d = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_x_held", 32'(x), 32'h1234);
            chk("bp_wr_held", 32'(wr), 5);
        end
        @(posedge clock); #1 out_ready = 1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (in_ready) begin ok = 1; break; end
        end
        chk("bp_release", 32'(ok), 1);
        @(posedge clock); #1 in_valid = 0;
        drain();

        send(4'd0, 16'hFFFF, 16'h0001, 3'd7, 4'd0);
        drain();
        send(4'd9, 16'h00FF, 16'h0000, 3'd2, 4'd8);
        @(posedge clock); #1 reset = 1;
        @(posedge clock); #1 reset = 0;
        @(negedge clock);
        chk("rstmid_out_valid", 32'(out_valid), 0);
        chk("rstmid_flags", 32'(flags), 0);
        chk("rstmid_in_ready", 32'(in_ready), 1);
        repeat (12) @(posedge clock);
        #1;

        rnd_bp = 1;
        for (int k = 0; k < 80; k++) begin
            send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        end
        rnd_bp = 0;
        @(posedge clock); #1 out_ready = 1;
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
